// File: rtl/mips_regfile_mp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mips_regfile_mp                                               |
// | Purpose  : Multi-read, dual-write MIPS register file with busy scoreboard |
// |            Optional write-to-read bypass: define REGFILE_BYPASS_EN.       |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module mips_regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     w0_en,
  input  logic [ADDR_W-1:0]        w0_dest,
  input  logic [DATA_W-1:0]        w0_data,
  input  logic                     w1_en,
  input  logic [ADDR_W-1:0]        w1_dest,
  input  logic [DATA_W-1:0]        w1_data,
  input  logic                     sb_set_en,
  input  logic [ADDR_W-1:0]        sb_set_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int c_DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0]  r_mem [c_DEPTH];
  logic [c_DEPTH-1:0] r_busy;
  logic [c_DEPTH-1:0] w_busy_next;
  logic [ADDR_W:0]    w_cnt;
  logic               w_w0_ok;
  logic               w_w1_ok;
  logic               w_set_ok;

  // Register 0 is hardwired, so every update path is qualified by a nonzero address.
  assign w_w0_ok  = w0_en && (w0_dest != '0);
  assign w_w1_ok  = w1_en && (w1_dest != '0);
  assign w_set_ok = sb_set_en && (sb_set_addr != '0);

  // Set is applied last so a load issued as the previous result retires stays pending.
  always_comb begin
    w_busy_next = r_busy;
    if (w_w0_ok)  w_busy_next[w0_dest]     = 1'b0;
    if (w_w1_ok)  w_busy_next[w1_dest]     = 1'b0;
    if (w_set_ok) w_busy_next[sb_set_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < c_DEPTH; i++) r_mem[i] <= '0;
      r_busy <= '0;
    end else begin
      if (w_w0_ok) r_mem[w0_dest] <= w0_data;
      if (w_w1_ok) r_mem[w1_dest] <= w1_data;
      r_busy <= w_busy_next;
    end
  end

  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < c_DEPTH; i++) w_cnt = w_cnt + {{ADDR_W{1'b0}}, r_busy[i]};
  end
  assign busy_cnt = w_cnt;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic              w_bsy;

    assign w_addr = rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      w_data = r_mem[w_addr];
      w_bsy  = r_busy[w_addr];
`ifdef REGFILE_BYPASS_EN
      // Forwarding is suppressed under reset so reads stay zero while rst is high.
      if (!rst) begin
        if (w_w1_ok && (w1_dest == w_addr))      w_data = w1_data;
        else if (w_w0_ok && (w0_dest == w_addr)) w_data = w0_data;
        w_bsy = w_busy_next[w_addr];
      end
`endif
      if (w_addr == '0) begin
        w_data = '0;
        w_bsy  = 1'b0;
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = w_data;
    assign rd_busy[k]                  = w_bsy;
  end

endmodule
`default_nettype wire

// File: tb/tb_mips_regfile_mp.sv
`default_nettype none
// Bench for mips_regfile_mp at DATA_W=64, ADDR_W=6, NUM_RD=4: array/scoreboard model,
// per-cycle compare, directed scenarios with literal expectations, then random traffic.
module tb_mips_regfile_mp;
  localparam int DW = 64;
  localparam int AW = 6;
  localparam int NR = 4;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst;
  logic w0_en, w1_en, sb_set_en;
  logic [AW-1:0] w0_dest, w1_dest, sb_set_addr;
  logic [DW-1:0] w0_data, w1_data;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0] rd_busy;
  logic [AW:0] busy_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mips_regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
    .clk(clk), .rst(rst),
    .w0_en(w0_en), .w0_dest(w0_dest), .w0_data(w0_data),
    .w1_en(w1_en), .w1_dest(w1_dest), .w1_data(w1_data),
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy), .busy_cnt(busy_cnt)
  );

  // Reference state: plain arrays updated by the architectural rules.
  logic [DW-1:0] m_mem [DEPTH];
  logic          m_busy [DEPTH];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_mem[i]  = '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (w0_en && w0_dest != 0) begin m_mem[w0_dest] = w0_data; m_busy[w0_dest] = 1'b0; end
      if (w1_en && w1_dest != 0) begin m_mem[w1_dest] = w1_data; m_busy[w1_dest] = 1'b0; end
      if (sb_set_en && sb_set_addr != 0) m_busy[sb_set_addr] = 1'b1;
    end
  end

  function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
    if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (!rst && w1_en && w1_dest == a) return w1_data;
    if (!rst && w0_en && w0_dest == a) return w0_data;
`endif
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (!rst) begin
      if (sb_set_en && sb_set_addr == a) return 1'b1;
      if ((w0_en && w0_dest == a) || (w1_en && w1_dest == a)) return 1'b0;
    end
`endif
    return m_busy[a];
  endfunction

  function automatic int exp_cnt();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  function automatic logic [DW-1:0] pat(input int r);
    logic [DW-1:0] v;
    v = 64'h9E3779B97F4A7C15 * DW'(r);
    return v ^ DW'(r);
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < NR; k++) begin
      chk($sformatf("rd_data[%0d]", k), rd_data[k*DW +: DW], exp_data(rd_addr[k*AW +: AW]));
      chk($sformatf("rd_busy[%0d]", k), DW'(rd_busy[k]), DW'(exp_busy(rd_addr[k*AW +: AW])));
    end
    chk("busy_cnt", DW'(busy_cnt), DW'(exp_cnt()));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    w0_en = 0; w1_en = 0; sb_set_en = 0;
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 7));
    return AW'($urandom_range(0, DEPTH - 1));
  endfunction

  initial begin
    rst = 0; idle();
    w0_dest = '0; w1_dest = '0; sb_set_addr = '0;
    w0_data = '0; w1_data = '0; rd_addr = '0;
    #1 rst = 1;
    repeat (2) @(posedge clk);
    #3 rst = 0;
    tick();
    @(negedge clk);
    chk("reset_busy_cnt", DW'(busy_cnt), 0);
    chk("reset_rd0", rd_data[0 +: DW], 0);

    // Asynchronous reset with a write pending discards the write.
    tick();
    w0_en = 1; w0_dest = 5; w0_data = 64'hDEADBEEF; rd_addr = {NR{6'd5}};
    tick();
    idle();
    @(negedge clk);
    chk("r5_written", rd_data[0 +: DW], 64'hDEADBEEF);
    #1;
    w0_en = 1; w0_data = 64'h1111; sb_set_en = 1; sb_set_addr = 6;
    #1 rst = 1;
    #1;
    chk("r5_async_reset", rd_data[0 +: DW], 0);
    chk("cnt_async_reset", DW'(busy_cnt), 0);
    sb_set_en = 0;
    @(posedge clk);
    #2 rst = 0;
    tick();
    idle();
    @(negedge clk);
    chk("r5_first_after_release", rd_data[0 +: DW], 64'h1111);

    // Register 0 ignores writes and busy sets.
    tick();
    w0_en = 1; w0_dest = 0; w0_data = '1;
    w1_en = 1; w1_dest = 0; w1_data = '1;
    sb_set_en = 1; sb_set_addr = 0; rd_addr = '0;
    tick();
    idle();
    @(negedge clk);
    chk("r0_data", rd_data[0 +: DW], 0);
    chk("r0_busy", DW'(rd_busy[0]), 0);
    chk("r0_cnt", DW'(busy_cnt), 0);

    // Same-destination collision: port 1 wins.
    tick();
    w0_en = 1; w0_dest = 7; w0_data = 64'h11;
    w1_en = 1; w1_dest = 7; w1_data = 64'h22; rd_addr = {NR{6'd7}};
    tick();
    idle();
    @(negedge clk);
    for (int k = 0; k < NR; k++) chk($sformatf("collision_port%0d", k), rd_data[k*DW +: DW], 64'h22);

    // Scoreboard set/clear/priority.
    tick();
    sb_set_en = 1; sb_set_addr = 3;
    tick();
    sb_set_addr = 4;
    tick();
    idle();
    @(negedge clk);
    chk("sb_cnt_two", DW'(busy_cnt), 2);
    tick();
    w1_en = 1; w1_dest = 3; w1_data = 64'h33; rd_addr = {NR{6'd3}};
    tick();
    idle();
    @(negedge clk);
    chk("sb_cnt_one", DW'(busy_cnt), 1);
    chk("sb_r3_clear", DW'(rd_busy[0]), 0);
    tick();
    sb_set_en = 1; sb_set_addr = 4; w0_en = 1; w0_dest = 4; w0_data = 64'h55; rd_addr = {NR{6'd4}};
    tick();
    idle();
    @(negedge clk);
    chk("sb_r4_busy", DW'(rd_busy[0]), 1);
    chk("sb_r4_data", rd_data[0 +: DW], 64'h55);
    chk("sb_r4_cnt", DW'(busy_cnt), 1);

    // Write-to-read visibility on r9.
    tick();
    w0_en = 1; w0_dest = 9; w0_data = 64'h1234;
    tick();
    w0_data = 64'hCAFE; rd_addr = {NR{6'd9}};
    @(negedge clk);
`ifdef REGFILE_BYPASS_EN
    chk("bypass_same_cycle", rd_data[DW +: DW], 64'hCAFE);
`else
    chk("bypass_same_cycle", rd_data[DW +: DW], 64'h1234);
`endif
    tick();
    idle();
    @(negedge clk);
    chk("bypass_after_edge", rd_data[DW +: DW], 64'hCAFE);

    // Full-depth pattern fill and readback across all ports.
    for (int r = 1; r < DEPTH; r += 2) begin
      tick();
      w0_en = 1; w0_dest = AW'(r); w0_data = pat(r);
      w1_en = (r + 1 < DEPTH); w1_dest = AW'(r + 1); w1_data = pat(r + 1);
    end
    tick();
    idle();
    for (int r = 0; r < DEPTH; r++) begin
      for (int k = 0; k < NR; k++) rd_addr[k*AW +: AW] = AW'((r + k) % DEPTH);
      @(negedge clk);
      for (int k = 0; k < NR; k++)
        chk($sformatf("sweep_r%0d_p%0d", (r + k) % DEPTH, k), rd_data[k*DW +: DW],
            ((r + k) % DEPTH == 0) ? '0 : pat((r + k) % DEPTH));
      tick();
    end

    // Random traffic with occasional mid-cycle reset pulses.
    for (int n = 0; n < 800; n++) begin
      tick();
      w0_en = 1'($urandom_range(0, 1)); w0_dest = rnd_addr();
      w0_data = {$urandom, $urandom};
      w1_en = 1'($urandom_range(0, 1)); w1_dest = rnd_addr();
      w1_data = {$urandom, $urandom};
      sb_set_en = 1'($urandom_range(0, 1)); sb_set_addr = rnd_addr();
      for (int k = 0; k < NR; k++) rd_addr[k*AW +: AW] = rnd_addr();
      if ($urandom_range(0, 99) == 0) begin
        #1 rst = 1;
        #1 rst = 0;
      end
    end
    tick();
    idle();
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mips_regfile_mp.md
# mips_regfile_mp

Parametrised multi-port register file for the 32-bit MIPS cores. It generalises the single-write, two-read file to configurable data width, depth and read-port count, and adds a second write port for dual-issue and load writeback. A per-register busy scoreboard lets the issue stage stall on pending loads. It sits between decode/issue (read side) and writeback (write side).

## Interface
- `DATA_W`, 32, register width in bits
- `ADDR_W`, 5, address width; depth = 2^ADDR_W
- `NUM_RD`, 2, number of read ports (1..8)

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `w0_en`  in  1  write port 0 enable (ALU writeback)
- `w0_dest`  in  ADDR_W  write port 0 destination
- `w0_data`  in  DATA_W  write port 0 data
- `w1_en`  in  1  write port 1 enable (load writeback)
- `w1_dest`  in  ADDR_W  write port 1 destination
- `w1_data`  in  DATA_W  write port 1 data
- `sb_set_en`  in  1  mark register pending (load issued)
- `sb_set_addr`  in  ADDR_W  register to mark pending
- `rd_addr`  in  NUM_RD*ADDR_W  packed read addresses; port k at bits [k*ADDR_W +: ADDR_W]
- `rd_data`  out  NUM_RD*DATA_W  packed read data, same packing
- `rd_busy`  out  NUM_RD  busy bit of each addressed register
- `busy_cnt`  out  ADDR_W+1  number of registers currently pending

## Operation
- Storage: 2^ADDR_W × DATA_W array plus a 2^ADDR_W busy vector.
- Register 0:
  - Reads return 0 and `rd_busy` = 0.
  - Writes and `sb_set` to address 0 are ignored.
- Writes occur at the clock edge when `wN_en` = 1.
  - If both ports target the same nonzero destination in one cycle, w1 data is stored.
- Scoreboard, per register r ≠ 0, per cycle:
  - `sb_set_en` with addr r sets busy[r].
  - An enabled write to r (either port) clears busy[r].
  - If a set and a write to r occur in the same cycle, the set wins and busy[r] ends at 1 (new load issued as the old result retires). The data is still written.
  - A set on an already-busy register leaves it busy.
- `busy_cnt` is the population count of the busy vector after the edge. Range is 0..2^ADDR_W−1.
- Reads are combinational. Every read port is independent; any number of ports may address the same register.

## Timing
- Reset (asynchronous, takes effect immediately):
  - All array entries = 0, busy vector = 0.
  - Hence `rd_data` = 0, `rd_busy` = 0, `busy_cnt` = 0 while `rst` is high and after release.
- Write latency is 1 cycle: data written at edge N is visible on `rd_data` from edge N onward (same-cycle visibility depends on Configuration).
- A busy set at edge N is visible on `rd_busy` and `busy_cnt` after edge N.
- Reset asserted mid-cycle, including with writes pending, discards those writes. The first write accepted after release is the one sampled at the first rising edge with `rst` low.

## Configuration
- `REGFILE_BYPASS_EN`:
  - **Defined:** a read port whose nonzero address matches an enabled write in the current cycle returns that write's data combinationally (w1 over w0 if both match). `rd_busy` for that port reports the post-edge busy value, i.e. 0 unless `sb_set` targets the same register this cycle.
  - **Undefined:** reads return the stored array value and current busy bit; write data appears only after the edge.

## Test plan
- **Reset:** write 0xDEADBEEF to r5, assert `rst` asynchronously mid-cycle. → `rd_data` for r5 reads 0 immediately; `busy_cnt` = 0.
- **r0:** write 0xFFFFFFFF to r0 via both ports and `sb_set` r0. → reads of r0 return 0, `rd_busy` = 0, `busy_cnt` = 0.
- **Write collision:** w0 writes 0x11 and w1 writes 0x22 to r7 in the same cycle. → r7 reads 0x22 next cycle on all NUM_RD ports.
- **Scoreboard:**
  - `sb_set` r3 and r4. → `busy_cnt` = 2.
  - w1 writes r3. → `busy_cnt` = 1, r3 not busy.
  - Same cycle: `sb_set` r4 plus w0 write r4 = 0x55. → r4 busy, reads 0x55, `busy_cnt` = 1.
- **Bypass:** w0 writes 0xCAFE to r9 while port 1 reads r9.
  - With `REGFILE_BYPASS_EN`: 0xCAFE the same cycle.
  - Without it: old value, then 0xCAFE after the edge.
- **Parameter sweep:** DATA_W=64, ADDR_W=6, NUM_RD=4. Write a distinct pattern to r1..r63, read back on all ports. → exact match; r0 reads 0.
